// File: rtl/colour_filter_pkg.sv
// Shared constants for the colour filter: register map, MODE bit positions,
// control FSM encoding and register reset values.
`timescale 1ns/1ps
package colour_filter_pkg;

    localparam int NUM_REGS = 7;

    localparam logic [2:0] ADDR_R_MIN = 3'd0;
    localparam logic [2:0] ADDR_R_MAX = 3'd1;
    localparam logic [2:0] ADDR_G_MIN = 3'd2;
    localparam logic [2:0] ADDR_G_MAX = 3'd3;
    localparam logic [2:0] ADDR_B_MIN = 3'd4;
    localparam logic [2:0] ADDR_B_MAX = 3'd5;
    localparam logic [2:0] ADDR_MODE  = 3'd6;
    localparam logic [2:0] ADDR_RSVD  = 3'd7;

    localparam int MODE_ENABLE_BIT = 0;
    localparam int MODE_INVERT_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_APPLY   = 2'd2
    } state_t;

    // MAX registers (odd addresses) reset wide open; MIN and MODE reset to zero.
    function automatic logic [7:0] reg_reset_val(input int idx);
        return (idx == 1 || idx == 3 || idx == 5) ? 8'hFF : 8'h00;
    endfunction

endpackage

// File: rtl/chan_range_cmp.sv
// Inclusive unsigned range check for one colour channel; MIN > MAX never matches.
`timescale 1ns/1ps
module chan_range_cmp (
    input  logic [7:0] i_value,
    input  logic [7:0] i_min,
    input  logic [7:0] i_max,
    output logic       o_in_range
);

    assign o_in_range = (i_value >= i_min) && (i_value <= i_max);

endmodule

// File: rtl/colour_filter_ctrl.sv
// Colour range filter with CPU shadow registers committed atomically at the
// next VS falling edge, a 2-stage pixel pipeline and per-frame match counting.
`timescale 1ns/1ps
module colour_filter_ctrl
    import colour_filter_pkg::*;
#(
    parameter int CNT_W = 19
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iWR,
    input  logic [2:0]       iADDR,
    input  logic [7:0]       iWDATA,
    output logic             oWR_ACK,
    input  logic             iCOMMIT,
    output logic             oCOMMIT_PEND,
    input  logic             iVGA_VS,
    input  logic             iPIX_VALID,
    input  logic [7:0]       iR,
    input  logic [7:0]       iG,
    input  logic [7:0]       iB,
    output logic [7:0]       oR,
    output logic [7:0]       oG,
    output logic [7:0]       oB,
    output logic             oMATCH,
    output logic [15:0]      oFRAME_CNT,
    output logic [CNT_W-1:0] oMATCH_CNT
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    w_commit_pend;
    logic                    r_vs;
    logic                    w_vs_fall;
    logic                    r_wr_ack;
    logic [15:0]             r_frame_cnt;
    logic [NUM_REGS-1:0][7:0] w_active;
    logic [2:0][7:0]         w_chan;
    logic [2:0]              w_in_range;
    logic                    w_match;
    logic                    r_s1_match;
    logic [23:0]             r_s1_pix;
    logic [23:0]             w_out_pix;
    logic                    r_out_match;
    logic [23:0]             r_out_pix;
    logic [CNT_W-1:0]        r_match_cnt;
    logic [CNT_W-1:0]        r_match_cnt_out;
    logic                    w_unused_mode;

    assign w_vs_fall = r_vs & ~iVGA_VS;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state     <= ST_IDLE;
            r_vs        <= 1'b1;
            r_wr_ack    <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_vs     <= iVGA_VS;
            r_wr_ack <= iWR;
            if (r_state == ST_APPLY)
                r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_commit_pend = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (iCOMMIT)
                    w_state_next = ST_PENDING;
            end
            ST_PENDING: begin
                w_commit_pend = 1'b1;
                if (w_vs_fall)
                    w_state_next = ST_APPLY;
            end
            ST_APPLY: begin
                w_commit_pend = 1'b1;
                w_state_next  = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // The active copy samples the shadow before any write in the APPLY cycle lands.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
            logic [7:0] r_shadow;
            logic [7:0] r_active;
            always_ff @(posedge iCLK or negedge iRST_N) begin
                if (!iRST_N) begin
                    r_shadow <= reg_reset_val(gi);
                    r_active <= reg_reset_val(gi);
                end else begin
                    if (iWR && (iADDR == 3'(gi)))
                        r_shadow <= iWDATA;
                    if (r_state == ST_APPLY)
                        r_active <= r_shadow;
                end
            end
            assign w_active[gi] = r_active;
        end
    endgenerate

    assign w_unused_mode = ^w_active[ADDR_MODE][7:2];

    assign w_chan[0] = iR;
    assign w_chan[1] = iG;
    assign w_chan[2] = iB;

    generate
        for (gi = 0; gi < 3; gi++) begin : g_cmp
            chan_range_cmp u_cmp (
                .i_value   (w_chan[gi]),
                .i_min     (w_active[2*gi]),
                .i_max     (w_active[2*gi+1]),
                .o_in_range(w_in_range[gi])
            );
        end
    endgenerate

    assign w_match = iPIX_VALID & (&w_in_range);

    always_comb begin
        w_out_pix = r_s1_pix;
        if (w_active[ADDR_MODE][MODE_ENABLE_BIT]) begin
            if (w_active[ADDR_MODE][MODE_INVERT_BIT])
                w_out_pix = r_s1_match ? 24'd0 : r_s1_pix;
            else
                w_out_pix = r_s1_match ? r_s1_pix : 24'd0;
        end
    end

    // Invalid pixels are zeroed at stage 1 so every mode emits 0 for them.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_s1_match  <= 1'b0;
            r_s1_pix    <= '0;
            r_out_match <= 1'b0;
            r_out_pix   <= '0;
        end else begin
            r_s1_match  <= w_match;
            r_s1_pix    <= iPIX_VALID ? {iR, iG, iB} : 24'd0;
            r_out_match <= r_s1_match;
            r_out_pix   <= w_out_pix;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_match_cnt     <= '0;
            r_match_cnt_out <= '0;
        end else if (w_vs_fall) begin
            r_match_cnt_out <= r_match_cnt;
            r_match_cnt     <= CNT_W'(r_s1_match);
        end else if (r_s1_match && (r_match_cnt != '1)) begin
            r_match_cnt <= r_match_cnt + 1'b1;
        end
    end

    assign oWR_ACK      = r_wr_ack;
    assign oCOMMIT_PEND = w_commit_pend;
    assign oR           = r_out_pix[23:16];
    assign oG           = r_out_pix[15:8];
    assign oB           = r_out_pix[7:0];
    assign oMATCH       = r_out_match;
    assign oFRAME_CNT   = r_frame_cnt;
    assign oMATCH_CNT   = r_match_cnt_out;

endmodule

// File: tb/tb_colour_filter_ctrl.sv
// Directed bench for colour_filter_ctrl: pixel expectations go through a
// scoreboard queue, register/commit/count behaviour is asserted inline.
`timescale 1ns/1ps
module tb_colour_filter_ctrl;

    localparam int CNT_W = 19;

    logic             iCLK = 1'b0;
    logic             iRST_N = 1'b0;
    logic             iWR = 1'b0;
    logic [2:0]       iADDR = '0;
    logic [7:0]       iWDATA = '0;
    logic             oWR_ACK;
    logic             iCOMMIT = 1'b0;
    logic             oCOMMIT_PEND;
    logic             iVGA_VS = 1'b1;
    logic             iPIX_VALID = 1'b0;
    logic [7:0]       iR = '0;
    logic [7:0]       iG = '0;
    logic [7:0]       iB = '0;
    logic [7:0]       oR;
    logic [7:0]       oG;
    logic [7:0]       oB;
    logic             oMATCH;
    logic [15:0]      oFRAME_CNT;
    logic [CNT_W-1:0] oMATCH_CNT;

    colour_filter_ctrl #(.CNT_W(CNT_W)) dut (
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .iWR         (iWR),
        .iADDR       (iADDR),
        .iWDATA      (iWDATA),
        .oWR_ACK     (oWR_ACK),
        .iCOMMIT     (iCOMMIT),
        .oCOMMIT_PEND(oCOMMIT_PEND),
        .iVGA_VS     (iVGA_VS),
        .iPIX_VALID  (iPIX_VALID),
        .iR          (iR),
        .iG          (iG),
        .iB          (iB),
        .oR          (oR),
        .oG          (oG),
        .oB          (oB),
        .oMATCH      (oMATCH),
        .oFRAME_CNT  (oFRAME_CNT),
        .oMATCH_CNT  (oMATCH_CNT)
    );

    always #20 iCLK = ~iCLK;

    typedef struct {
        int          due;
        logic [24:0] exp;
    } sb_t;

    sb_t        sb_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic [7:0] m_sh[7];
    logic [7:0] m_act[7];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_defaults();
        for (int i = 0; i < 7; i++) begin
            m_sh[i]  = (i == 1 || i == 3 || i == 5) ? 8'hFF : 8'h00;
            m_act[i] = m_sh[i];
        end
    endfunction

    function automatic logic [24:0] model(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b, input logic v);
        logic [7:0]  ch[3];
        logic        m;
        logic [23:0] p;
        ch[0] = r; ch[1] = g; ch[2] = b;
        m = v;
        for (int i = 0; i < 3; i++)
            if (ch[i] < m_act[2*i] || ch[i] > m_act[2*i+1]) m = 1'b0;
        p = v ? {r, g, b} : 24'd0;
        if (m_act[6][0]) p = (m ^ m_act[6][1]) ? p : 24'd0;
        return {m, p};
    endfunction

    // Output of a pixel driven after posedge c appears after posedge c+2.
    always @(posedge iCLK) begin
        sb_t e;
        cyc = cyc + 1;
        #1;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            check("pixel", {7'd0, oMATCH, oR, oG, oB}, {7'd0, e.exp});
        end
    end

    task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input logic v);
        sb_t e;
        @(negedge iCLK);
        iPIX_VALID = v; iR = r; iG = g; iB = b;
        e.due = cyc + 2;
        e.exp = model(r, g, b, v);
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge iCLK);
            iPIX_VALID = 1'b0; iR = '0; iG = '0; iB = '0;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge iCLK);
        iPIX_VALID = 1'b0;
        iWR = 1'b1; iADDR = a; iWDATA = d;
        if (a != 3'd7) m_sh[a] = d;
        @(negedge iCLK);
        iWR = 1'b0;
        check("wr_ack", 32'(oWR_ACK), 32'd1);
    endtask

    task automatic commit();
        @(negedge iCLK);
        iCOMMIT = 1'b1;
        @(negedge iCLK);
        iCOMMIT = 1'b0;
    endtask

    task automatic vs_pulse();
        @(negedge iCLK);
        iPIX_VALID = 1'b0;
        iVGA_VS = 1'b0;
        repeat (3) @(negedge iCLK);
        iVGA_VS = 1'b1;
        @(negedge iCLK);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_defaults();
        repeat (3) @(negedge iCLK);
        check("rst_pix", {7'd0, oMATCH, oR, oG, oB}, 32'd0);
        check("rst_pend_ack", {oCOMMIT_PEND, oWR_ACK}, 32'd0);
        check("rst_frame", 32'(oFRAME_CNT), 32'd0);
        check("rst_mcnt", 32'(oMATCH_CNT), 32'd0);
        iRST_N = 1'b1;

        // Defaults pass everything through with a match
        send(8'd12, 8'd200, 8'd7, 1'b1);
        send(8'd1, 8'd2, 8'd3, 1'b0);
        idle(3);
        wr(3'd7, 8'h55);

        // Filtering with ENABLE
        wr(3'd0, 8'd100); wr(3'd1, 8'd150);
        wr(3'd2, 8'd0);   wr(3'd3, 8'd50);
        wr(3'd4, 8'd0);   wr(3'd5, 8'd50);
        wr(3'd6, 8'h01);
        commit();
        check("pend_after_commit", 32'(oCOMMIT_PEND), 32'd1);
        vs_pulse();
        m_act = m_sh;
        check("pend_after_apply", 32'(oCOMMIT_PEND), 32'd0);
        check("frame_1", 32'(oFRAME_CNT), 32'd1);
        send(8'd120, 8'd10, 8'd10, 1'b1);
        send(8'd160, 8'd10, 8'd10, 1'b1);
        send(8'd100, 8'd50, 8'd0, 1'b1);
        send(8'd151, 8'd10, 8'd10, 1'b1);
        send(8'd99, 8'd10, 8'd10, 1'b1);
        send(8'd120, 8'd10, 8'd10, 1'b0);
        idle(3);

        // Write while pending joins the commit; write in APPLY stays in shadow
        commit();
        wr(3'd6, 8'h03);
        check("pend_during_pending", 32'(oCOMMIT_PEND), 32'd1);
        @(negedge iCLK);
        iVGA_VS = 1'b0;
        @(negedge iCLK);
        check("pend_in_apply", 32'(oCOMMIT_PEND), 32'd1);
        iWR = 1'b1; iADDR = 3'd6; iWDATA = 8'hFC;
        m_act = m_sh;
        m_sh[6] = 8'hFC;
        @(negedge iCLK);
        iWR = 1'b0;
        check("wr_ack_apply", 32'(oWR_ACK), 32'd1);
        check("pend_after_apply2", 32'(oCOMMIT_PEND), 32'd0);
        check("frame_2", 32'(oFRAME_CNT), 32'd2);
        @(negedge iCLK);
        iVGA_VS = 1'b1;
        send(8'd120, 8'd10, 8'd10, 1'b1);
        send(8'd160, 8'd10, 8'd10, 1'b1);
        idle(3);

        // Commit coinciding with a VS fall waits for the next one
        @(negedge iCLK);
        iCOMMIT = 1'b1; iVGA_VS = 1'b0;
        @(negedge iCLK);
        iCOMMIT = 1'b0;
        repeat (3) @(negedge iCLK);
        check("pend_coincident", 32'(oCOMMIT_PEND), 32'd1);
        check("frame_not_yet", 32'(oFRAME_CNT), 32'd2);
        iVGA_VS = 1'b1;
        vs_pulse();
        m_act = m_sh;
        check("frame_3", 32'(oFRAME_CNT), 32'd3);
        send(8'd120, 8'd10, 8'd10, 1'b1);
        send(8'd160, 8'd10, 8'd10, 1'b1);
        idle(3);
        vs_pulse();
        check("mcnt_prev", 32'(oMATCH_CNT), 32'd1);

        // Frame counting
        for (int i = 0; i < 300; i++) send(8'd120, 8'd10, 8'd10, 1'b1);
        for (int i = 0; i < 50; i++) send(8'd200, 8'd10, 8'd10, 1'b1);
        idle(2);
        vs_pulse();
        check("mcnt_300", 32'(oMATCH_CNT), 32'd300);
        for (int i = 0; i < 5; i++) send(8'd130, 8'd20, 8'd30, 1'b1);
        vs_pulse();
        check("mcnt_restart", 32'(oMATCH_CNT), 32'd4);
        vs_pulse();
        check("mcnt_edge_pixel", 32'(oMATCH_CNT), 32'd1);

        // MIN > MAX and a redundant commit while pending
        wr(3'd0, 8'd200); wr(3'd1, 8'd100);
        commit();
        commit();
        check("pend_double", 32'(oCOMMIT_PEND), 32'd1);
        vs_pulse();
        m_act = m_sh;
        check("frame_4", 32'(oFRAME_CNT), 32'd4);
        vs_pulse();
        check("frame_once", 32'(oFRAME_CNT), 32'd4);
        check("pend_idle", 32'(oCOMMIT_PEND), 32'd0);
        send(8'd150, 8'd10, 8'd10, 1'b1);
        send(8'd200, 8'd10, 8'd10, 1'b1);
        send(8'd100, 8'd10, 8'd10, 1'b1);
        send(8'd0, 8'd0, 8'd0, 1'b1);
        idle(3);

        // Reset while pending discards the commit
        wr(3'd0, 8'd5);
        commit();
        check("pend_before_rst", 32'(oCOMMIT_PEND), 32'd1);
        @(negedge iCLK);
        iRST_N = 1'b0;
        #1;
        check("rst_pend", 32'(oCOMMIT_PEND), 32'd0);
        check("rst_frame2", 32'(oFRAME_CNT), 32'd0);
        check("rst_mcnt2", 32'(oMATCH_CNT), 32'd0);
        model_defaults();
        @(negedge iCLK);
        iRST_N = 1'b1;
        vs_pulse();
        check("rst_no_apply_pend", 32'(oCOMMIT_PEND), 32'd0);
        check("rst_no_apply_frame", 32'(oFRAME_CNT), 32'd0);
        send(8'd12, 8'd200, 8'd7, 1'b1);
        send(8'd255, 8'd255, 8'd255, 1'b1);
        send(8'd0, 8'd0, 8'd0, 1'b1);
        idle(4);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
